// File: rtl/rect_draw_sequencer.sv
// rect_draw_sequencer: accepts a rectangle/clear command and walks the clipped
// rectangle row-major, emitting one pixel per valid/ready transfer.
module rect_draw_sequencer #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x,
  input  logic [Y_W-1:0]      cmd_y,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  input  logic                cmd_clear,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);
  state_t state, state_n;
  logic [X_W-1:0] x0, w, xe, cur_x;
  logic [Y_W-1:0] y0, h, ye, cur_y;
  logic clear, empty, last;
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  assign x_sum = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
  assign y_sum = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);
  assign empty = !clear && (w == '0 || h == '0 || {1'b0, x0} > X_MAX || {1'b0, y0} > Y_MAX);
  assign last = cur_x == xe && cur_y == ye;
  assign cmd_ready = state == IDLE;
  assign pix_valid = state == DRAW;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign pix_x = cur_x;
  assign pix_y = cur_y;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cmd_valid ? SETUP : IDLE;
      SETUP:   state_n = empty ? DONE : DRAW;
      DRAW:    state_n = (pix_ready && last) ? DONE : DRAW;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      {x0, w, xe, cur_x} <= '0;
      {y0, h, ye, cur_y} <= '0;
      clear <= 1'b0;
      pix_colour <= '0;
    end else if (state == IDLE && cmd_valid) begin
      x0 <= cmd_x;
      y0 <= cmd_y;
      w <= cmd_w;
      h <= cmd_h;
      clear <= cmd_clear;
      pix_colour <= cmd_colour;
    end else if (state == SETUP) begin
      x0 <= clear ? '0 : x0;
      y0 <= clear ? '0 : y0;
      cur_x <= clear ? '0 : x0;
      cur_y <= clear ? '0 : y0;
      xe <= (clear || x_sum > X_MAX) ? X_MAX[X_W-1:0] : x_sum[X_W-1:0];
      ye <= (clear || y_sum > Y_MAX) ? Y_MAX[Y_W-1:0] : y_sum[Y_W-1:0];
    end else if (state == DRAW && pix_ready) begin
      // wrap to the row start; cur_y runs one past ye on the final pixel, harmlessly
      cur_x <= cur_x < xe ? cur_x + X_W'(1) : x0;
      cur_y <= cur_x < xe ? cur_y : cur_y + Y_W'(1);
    end
  end
endmodule

// File: tb/tb_rect_draw_sequencer.sv
// tb_rect_draw_sequencer: table-driven and randomized checks of rect_draw_sequencer
// against a loop-based model of the clipped rectangle.
module tb_rect_draw_sequencer;
  logic clk = 0, resetn = 0;
  logic cmd_valid = 0, cmd_ready, cmd_clear = 0;
  logic [7:0] cmd_x = 0, cmd_w = 0, pix_x;
  logic [6:0] cmd_y = 0, cmd_h = 0, pix_y;
  logic [2:0] cmd_colour = 0, pix_colour;
  logic pix_valid, pix_ready = 0, busy, done;
  int checks = 0, errors = 0;

  rect_draw_sequencer dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour), .cmd_clear(cmd_clear), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y;} px_t;
  typedef struct {int x, y, w, h, col, clr, mode, n, fx, fy, lx, ly;} vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // mode: 0 = pix_ready held high, 1 = toggling, 2 = random plus spurious cmd_valid
  task automatic run_cmd(input int x, y, w, h, col, clr, mode,
                         output int n, output int fx, fy, lx, ly);
    px_t q[$];
    px_t e;
    int cyc, last_cyc, px, py, pc, xend, yend, x0, y0;
    bit seen_done, pv, pr, nonempty;
    x0 = clr ? 0 : x;
    y0 = clr ? 0 : y;
    xend = clr ? 160 : (x + w < 160 ? x + w : 160);
    yend = clr ? 120 : (y + h < 120 ? y + h : 120);
    for (int yy = y0; yy < yend; yy++)
      for (int xx = x0; xx < xend; xx++) q.push_back('{xx, yy});
    nonempty = q.size() > 0;
    @(negedge clk);
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h);
    cmd_colour = 3'(col); cmd_clear = clr[0]; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("setup_busy", int'(busy), 1);
    chk("setup_no_pix", int'(pix_valid), 0);
    cyc = 1; n = 0; pv = 0; pr = 0; seen_done = 0; last_cyc = 0;
    fx = -1; fy = -1; lx = -1; ly = -1; px = 0; py = 0; pc = 0;
    while (!seen_done && cyc < 25000) begin
      @(negedge clk);
      cyc++;
      pix_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      cmd_valid = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_x = 8'($urandom); cmd_clear = 1'($urandom);
      if (done) begin
        seen_done = 1;
        chk("done_no_pix", int'(pix_valid), 0);
        chk("done_latency", cyc, nonempty ? last_cyc + 1 : 2);
      end else begin
        chk("busy_no_ready", int'(cmd_ready), 0);
        if (cyc == 2) chk("first_valid", int'(pix_valid), int'(nonempty));
        if (pv && !pr) begin
          chk("stall_valid", int'(pix_valid), 1);
          chk("stall_x", int'(pix_x), px);
          chk("stall_y", int'(pix_y), py);
          chk("stall_col", int'(pix_colour), pc);
        end
        if (pix_valid && pix_ready) begin
          if (q.size() == 0) chk("extra_pixel", n, -1);
          else begin
            e = q.pop_front();
            chk("pix_x", int'(pix_x), e.x);
            chk("pix_y", int'(pix_y), e.y);
            chk("pix_col", int'(pix_colour), col);
          end
          if (n == 0) begin fx = int'(pix_x); fy = int'(pix_y); end
          lx = int'(pix_x); ly = int'(pix_y);
          n++;
          last_cyc = cyc;
        end
        pv = pix_valid; pr = pix_ready;
        px = int'(pix_x); py = int'(pix_y); pc = int'(pix_colour);
      end
    end
    cmd_valid = 0;
    chk("done_seen", int'(seen_done), 1);
    chk("pixels_left", q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("ready_after_done", int'(cmd_ready), 1);
    chk("idle_not_busy", int'(busy), 0);
  endtask

  initial begin
    vec_t tbl[7];
    int n, fx, fy, lx, ly, cnt;
    tbl[0] = '{10, 5, 2, 2, 3, 0, 0, 4, 10, 5, 11, 6};
    tbl[1] = '{10, 5, 2, 2, 3, 0, 1, 4, 10, 5, 11, 6};
    tbl[2] = '{158, 118, 4, 4, 6, 0, 0, 4, 158, 118, 159, 119};
    tbl[3] = '{3, 4, 0, 5, 1, 0, 0, 0, -1, -1, -1, -1};
    tbl[4] = '{200, 0, 3, 3, 2, 0, 0, 0, -1, -1, -1, -1};
    tbl[5] = '{7, 9, 0, 0, 5, 1, 0, 19200, 0, 0, 159, 119};
    tbl[6] = '{0, 119, 255, 127, 7, 0, 2, 160, 0, 119, 159, 119};
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_xyc", int'({pix_x, pix_y, pix_colour}), 0);
    resetn = 1;
    foreach (tbl[i]) begin
      run_cmd(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].col, tbl[i].clr, tbl[i].mode,
              n, fx, fy, lx, ly);
      chk($sformatf("vec%0d_count", i), n, tbl[i].n);
      chk($sformatf("vec%0d_first", i), fx * 1000 + fy, tbl[i].fx * 1000 + tbl[i].fy);
      chk($sformatf("vec%0d_last", i), lx * 1000 + ly, tbl[i].lx * 1000 + tbl[i].ly);
    end
    for (int r = 0; r < 25; r++)
      run_cmd($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 12),
              $urandom_range(0, 6), $urandom_range(0, 7), 0, 2, n, fx, fy, lx, ly);
    // reset in the middle of a 4x4 draw
    @(negedge clk);
    cmd_x = 20; cmd_y = 20; cmd_w = 4; cmd_h = 4; cmd_colour = 4; cmd_clear = 0;
    cmd_valid = 1; pix_ready = 1;
    @(negedge clk);
    cmd_valid = 0;
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 3; c++) begin
      @(negedge clk);
      if (pix_valid && pix_ready) cnt++;
    end
    chk("mid_pixels", cnt, 3);
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    chk("mid_rst_valid", int'(pix_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_done", int'(done), 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(done) + int'(pix_valid);
    end
    chk("mid_rst_quiet", cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
